// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC owner and fetch sequencer for a synchronous-read instruction memory.
// Optional FETCH_STATS_EN adds saturating fetch/squash counters.
module instr_fetch_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
`ifdef FETCH_STATS_EN
    output logic [31:0]       fetch_count,
    output logic [15:0]       squash_count,
`endif
    output logic              busy,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc, last_addr, tgt;
    logic inflight, stall, issue;

    assign stall = inflight & ~instr_ready;
    assign issue = (state == RUN) & ~halt_req & (~stall | redirect_valid);
    assign tgt = redirect_valid ? redirect_addr : pc;
    // While an instruction is held, re-read its word so mem_data stays stable.
    assign mem_addr = issue ? tgt : (inflight ? last_addr : pc);
    assign instr = mem_data;
    assign instr_pc = last_addr;
    assign instr_valid = inflight;
    assign busy = (state == RUN) | (state == DRAIN);
    assign halted = (state == HALT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = halt_req ? DRAIN : RUN;
            DRAIN:   state_nxt = inflight ? DRAIN : HALT;
            default: state_nxt = start ? RUN : HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            last_addr <= RESET_PC;
            inflight  <= 1'b0;
        end else if (issue) begin
            pc        <= tgt + ADDR_W'(1);
            last_addr <= tgt;
            inflight  <= 1'b1;
        end else begin
            if (redirect_valid)
                pc <= redirect_addr;
            if (instr_ready)
                inflight <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else begin
            if (inflight && instr_ready && fetch_count != '1)
                fetch_count <= fetch_count + 32'd1;
            if (issue && redirect_valid && stall && squash_count != '1)
                squash_count <= squash_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed checks of instr_fetch_ctrl against a registered-read memory model.
module tb_instr_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
    logic [9:0]  redirect_addr = '0;
    logic [9:0]  mem_addr, instr_pc;
    logic [31:0] mem_data, instr;
    logic        instr_valid, busy, halted;
    logic [31:0] mem [1024];
    int total = 0, bad = 0;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] squash_count;
`endif

    instr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .mem_addr(mem_addr), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
`ifdef FETCH_STATS_EN
        .fetch_count(fetch_count), .squash_count(squash_count),
`endif
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        #2;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_instr_pc", {22'd0, instr_pc}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        // basic streaming
        start = 1'b1; instr_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_valid0", {31'd0, instr_valid}, 32'd0);
        chk("run_addr0", {22'd0, mem_addr}, 32'd0);
        @(negedge clk);
        chk("s_valid", {31'd0, instr_valid}, 32'd1);
        chk("s_pc0", {22'd0, instr_pc}, 32'd0);
        chk("s_i0", instr, 32'h1000_0000);
        @(negedge clk);
        chk("s_pc1", {22'd0, instr_pc}, 32'd1);
        chk("s_i1", instr, 32'h1000_0001);
        @(negedge clk);
        chk("s_pc2", {22'd0, instr_pc}, 32'd2);
        // stall on pc 2 for three cycles
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_addr", {22'd0, mem_addr}, 32'd2);
            chk("st_pc", {22'd0, instr_pc}, 32'd2);
            chk("st_instr", instr, 32'h1000_0002);
            chk("st_valid", {31'd0, instr_valid}, 32'd1);
            @(negedge clk);
        end
        chk("st_pc_end", {22'd0, instr_pc}, 32'd2);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("st_pc3", {22'd0, instr_pc}, 32'd3);
        chk("st_i3", instr, 32'h1000_0003);
        @(negedge clk);
        @(negedge clk);
        chk("pc5", {22'd0, instr_pc}, 32'd5);
        // redirect while stalled on pc 5
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 10'd100;
        #1 chk("rd_addr", {22'd0, mem_addr}, 32'd100);
        @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1;
        chk("rd_pc100", {22'd0, instr_pc}, 32'd100);
        chk("rd_i100", instr, 32'h1000_0064);
`ifdef FETCH_STATS_EN
        chk("squash", {16'd0, squash_count}, 32'd1);
`endif
        @(negedge clk);
        chk("rd_pc101", {22'd0, instr_pc}, 32'd101);
        // wrap at top of address space
        redirect_valid = 1'b1; redirect_addr = 10'd1023;
        @(negedge clk); redirect_valid = 1'b0;
        chk("wr_pc1023", {22'd0, instr_pc}, 32'd1023);
        chk("wr_i1023", instr, 32'h1000_03ff);
        @(negedge clk);
        chk("wr_pc0", {22'd0, instr_pc}, 32'd0);
        chk("wr_i0", instr, 32'h1000_0000);
        @(negedge clk);
        chk("wr_pc1", {22'd0, instr_pc}, 32'd1);
        // halt while pc 7 is held
        redirect_valid = 1'b1; redirect_addr = 10'd7;
        @(negedge clk); redirect_valid = 1'b0;
        chk("h_pc7", {22'd0, instr_pc}, 32'd7);
        instr_ready = 1'b0; halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        chk("dr_busy", {31'd0, busy}, 32'd1);
        chk("dr_halted", {31'd0, halted}, 32'd0);
        chk("dr_valid", {31'd0, instr_valid}, 32'd1);
        chk("dr_pc", {22'd0, instr_pc}, 32'd7);
        chk("dr_addr", {22'd0, mem_addr}, 32'd7);
        @(negedge clk);
        chk("dr_valid2", {31'd0, instr_valid}, 32'd1);
        chk("dr_halted2", {31'd0, halted}, 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("dr_valid3", {31'd0, instr_valid}, 32'd0);
        chk("dr_busy3", {31'd0, busy}, 32'd1);
        chk("dr_addr8", {22'd0, mem_addr}, 32'd8);
        @(negedge clk);
        chk("ht_halted", {31'd0, halted}, 32'd1);
        chk("ht_busy", {31'd0, busy}, 32'd0);
        chk("ht_addr", {22'd0, mem_addr}, 32'd8);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("rs_halted", {31'd0, halted}, 32'd0);
        chk("rs_addr", {22'd0, mem_addr}, 32'd8);
        @(negedge clk);
        chk("rs_pc8", {22'd0, instr_pc}, 32'd8);
        chk("rs_i8", instr, 32'h1000_0008);
        @(negedge clk);
        chk("rs_pc9", {22'd0, instr_pc}, 32'd9);
        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_addr", {22'd0, mem_addr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ar_idle_busy", {31'd0, busy}, 32'd0);
        chk("ar_idle_valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("ar_pc0", {22'd0, instr_pc}, 32'd0);
        chk("ar_valid_on", {31'd0, instr_valid}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
